// File: rtl/dmem_arbiter_pkg.sv
// Shared constants for the data-memory arbiter: Memory opcodes, RV32 width codes
// and the arbiter FSM state encoding.
package dmem_arbiter_pkg;

  localparam logic [6:0] MEM_OP_STORE = 7'b0100011;
  localparam logic [6:0] MEM_OP_LOAD  = 7'b0000011;
  localparam logic [6:0] MEM_OP_IDLE  = 7'b0000000;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_WAIT  = 2'b10,
    ST_ERR   = 2'b11
  } arb_state_e;

  function automatic logic [1:0] port_onehot(input logic port);
    return port ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Two-port request/response bundle between the requesters (pipeline, loader) and
// the data-memory arbiter. Index 0 is the pipeline, index 1 the loader.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [1:0]             req_valid;
  logic [1:0]             req_ready;
  logic [1:0]             req_we;
  logic [1:0][2:0]        req_funct3;
  logic [1:0][ADDR_W-1:0] req_addr;
  logic [1:0][DATA_W-1:0] req_wdata;
  logic [1:0]             rsp_valid;
  logic                   rsp_err;
  logic [DATA_W-1:0]      rsp_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/dmem_req_check.sv
// Combinational legality check of one memory request: funct3 legal for the
// direction, natural alignment, and the whole access inside MEM_BYTES.
module dmem_req_check
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 32
) (
  input  logic              we_i,
  input  logic [2:0]        funct3_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic              err_o
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_BYTES);

  logic [2:0]      size_s;
  logic            align_ok_s;
  logic            legal_s;
  logic [ADDR_W:0] last_byte_s;

  // Decode access size, alignment and direction legality from funct3.
  always_comb begin
    size_s     = 3'd1;
    align_ok_s = 1'b1;
    legal_s    = 1'b0;
    case (funct3_i)
      F3_B: begin
        size_s = 3'd1; align_ok_s = 1'b1; legal_s = 1'b1;
      end
      F3_H: begin
        size_s = 3'd2; align_ok_s = ~addr_i[0]; legal_s = 1'b1;
      end
      F3_W: begin
        size_s = 3'd4; align_ok_s = (addr_i[1:0] == 2'b00); legal_s = 1'b1;
      end
      F3_BU: begin
        size_s = 3'd1; align_ok_s = 1'b1; legal_s = ~we_i;
      end
      F3_HU: begin
        size_s = 3'd2; align_ok_s = ~addr_i[0]; legal_s = ~we_i;
      end
      default: begin
        size_s = 3'd1; align_ok_s = 1'b1; legal_s = 1'b0;
      end
    endcase
  end

  // One extra bit keeps the last-byte address from wrapping near the top of the space.
  assign last_byte_s = {1'b0, addr_i} + {{(ADDR_W-2){1'b0}}, size_s} - {{ADDR_W{1'b0}}, 1'b1};
  assign err_o       = ~(legal_s & align_ok_s & (last_byte_s < LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data Memory between the pipeline
// (port 0) and the loader (port 1); issues one access at a time and returns a response pulse.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int MEM_BYTES = 64,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  dmem_arbiter_if.slave   bus,
  output logic [6:0]      mem_ctrl,
  output logic [2:0]      mem_funct3,
  output logic [31:0]     mem_addr,
  output logic [31:0]     mem_wr_data,
  input  logic [31:0]     mem_rd_data
);

  arb_state_e state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        port_q, port_d;
  logic        we_q, we_d;
  logic        run_q;
  logic [6:0]  mem_ctrl_q, mem_ctrl_d;
  logic [2:0]  mem_funct3_q, mem_funct3_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wr_data_q, mem_wr_data_d;
  logic [1:0]  rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rdata_sel_q, rdata_sel_d;

  logic              grant_s;
  logic [1:0]        ready_s;
  logic              hs_s;
  logic              g_we_s;
  logic [2:0]        g_funct3_s;
  logic [ADDR_W-1:0] g_addr_s;
  logic [DATA_W-1:0] g_wdata_s;
  logic              chk_err_s;

  // Round-robin grant; ready is offered only in IDLE and only to the granted port.
  always_comb begin
    if (&bus.req_valid) begin
      grant_s = ~last_grant_q;
    end else begin
      grant_s = ~bus.req_valid[0];
    end
    if ((state_q == ST_IDLE) && run_q && (|bus.req_valid)) begin
      ready_s = port_onehot(grant_s);
    end else begin
      ready_s = 2'b00;
    end
  end

  assign hs_s       = |(ready_s & bus.req_valid);
  assign g_we_s     = bus.req_we[grant_s];
  assign g_funct3_s = bus.req_funct3[grant_s];
  assign g_addr_s   = bus.req_addr[grant_s];
  assign g_wdata_s  = bus.req_wdata[grant_s];

  dmem_req_check #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_req_check (
    .we_i     (g_we_s),
    .funct3_i (g_funct3_s),
    .addr_i   (g_addr_s),
    .err_o    (chk_err_s)
  );

  // FSM next state; mem_ctrl defaults to idle so a store is presented for exactly one cycle.
  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    port_d        = port_q;
    we_d          = we_q;
    mem_ctrl_d    = MEM_OP_IDLE;
    mem_funct3_d  = mem_funct3_q;
    mem_addr_d    = mem_addr_q;
    mem_wr_data_d = mem_wr_data_q;
    rsp_valid_d   = 2'b00;
    rsp_err_d     = 1'b0;
    rdata_sel_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hs_s) begin
          port_d       = grant_s;
          we_d         = g_we_s;
          last_grant_d = grant_s;
          if (chk_err_s) begin
            state_d     = ST_ERR;
            rsp_valid_d = port_onehot(grant_s);
            rsp_err_d   = 1'b1;
          end else begin
            state_d       = ST_ISSUE;
            mem_ctrl_d    = g_we_s ? MEM_OP_STORE : MEM_OP_LOAD;
            mem_funct3_d  = g_funct3_s;
            mem_addr_d    = 32'(g_addr_s);
            mem_wr_data_d = 32'(g_wdata_s);
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d     = ST_WAIT;
        rsp_valid_d = port_onehot(port_q);
        rdata_sel_d = ~we_q;
      end
      ST_WAIT: state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered outputs; reset aborts any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      last_grant_q  <= 1'b1;
      port_q        <= 1'b0;
      we_q          <= 1'b0;
      run_q         <= 1'b0;
      mem_ctrl_q    <= MEM_OP_IDLE;
      mem_funct3_q  <= 3'b000;
      mem_addr_q    <= 32'h0000_0000;
      mem_wr_data_q <= 32'h0000_0000;
      rsp_valid_q   <= 2'b00;
      rsp_err_q     <= 1'b0;
      rdata_sel_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      port_q        <= port_d;
      we_q          <= we_d;
      run_q         <= 1'b1;
      mem_ctrl_q    <= mem_ctrl_d;
      mem_funct3_q  <= mem_funct3_d;
      mem_addr_q    <= mem_addr_d;
      mem_wr_data_q <= mem_wr_data_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rdata_sel_q   <= rdata_sel_d;
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  // Memory read data is only valid in WAIT, so it is gated rather than re-registered.
  assign bus.rsp_rdata = rdata_sel_q ? DATA_W'(mem_rd_data) : {DATA_W{1'b0}};
  assign mem_ctrl      = mem_ctrl_q;
  assign mem_funct3    = mem_funct3_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wr_data   = mem_wr_data_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural 64-byte registered-read Memory.
module tb_dmem_arbiter;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } op_t;

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus();

  logic [6:0]  mem_ctrl;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data = 32'h0000_0000;
  logic [7:0]  mem_bytes [0:63] = '{default: 8'h00};

  dmem_arbiter #(.MEM_BYTES(64), .ADDR_W(32), .DATA_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .mem_ctrl    (mem_ctrl),
    .mem_funct3  (mem_funct3),
    .mem_addr    (mem_addr),
    .mem_wr_data (mem_wr_data),
    .mem_rd_data (mem_rd_data)
  );

  function automatic logic [31:0] mem_load(input logic [2:0] f3, input logic [5:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = mem_bytes[a];
    b1 = mem_bytes[a + 6'd1];
    b2 = mem_bytes[a + 6'd2];
    b3 = mem_bytes[a + 6'd3];
    case (f3)
      3'b000:  return {{24{b0[7]}}, b0};
      3'b001:  return {{16{b1[7]}}, b1, b0};
      3'b010:  return {b3, b2, b1, b0};
      3'b100:  return {24'h000000, b0};
      3'b101:  return {16'h0000, b1, b0};
      default: return 32'h0000_0000;
    endcase
  endfunction

  // Memory model: little-endian byte store, registered sign/zero-extending load
  always @(posedge clk) begin
    if (mem_ctrl == 7'b0100011) begin
      case (mem_funct3)
        3'b000: mem_bytes[mem_addr[5:0]] <= mem_wr_data[7:0];
        3'b001: begin
          mem_bytes[mem_addr[5:0]]         <= mem_wr_data[7:0];
          mem_bytes[mem_addr[5:0] + 6'd1] <= mem_wr_data[15:8];
        end
        3'b010: begin
          mem_bytes[mem_addr[5:0]]         <= mem_wr_data[7:0];
          mem_bytes[mem_addr[5:0] + 6'd1] <= mem_wr_data[15:8];
          mem_bytes[mem_addr[5:0] + 6'd2] <= mem_wr_data[23:16];
          mem_bytes[mem_addr[5:0] + 6'd3] <= mem_wr_data[31:24];
        end
        default: ;
      endcase
    end else if (mem_ctrl == 7'b0000011) begin
      mem_rd_data <= mem_load(mem_funct3, mem_addr[5:0]);
    end
  end

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   ctrl_cnt = 0;
  op_t  op0_q[$];
  op_t  op1_q[$];
  exp_t exp_q[$];
  int   hs_q[$];
  exp_t mon_e;
  int   mon_hs;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: pops the scoreboard on every rsp_valid pulse
  always @(posedge clk) begin
    #2;
    if (mem_ctrl != 7'b0000000) ctrl_cnt++;
    if (bus.rsp_valid != 2'b00) begin
      if (exp_q.size() == 0) begin
        chk("unexp_rsp", 32'(bus.rsp_valid), 32'h0);
      end else begin
        mon_e = exp_q.pop_front();
        chk("rsp_owner", 32'(bus.rsp_valid), 32'(mon_e.port ? 2'b10 : 2'b01));
        chk("rsp_err", 32'(bus.rsp_err), 32'(mon_e.err));
        chk("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
        if (hs_q.size() != 0) begin
          mon_hs = hs_q.pop_front();
          chk("rsp_latency", 32'(cyc - mon_hs), mon_e.err ? 32'd1 : 32'd2);
        end else begin
          chk("rsp_no_hs", 32'(hs_q.size()), 32'd1);
        end
      end
    end
  end

  task automatic queue_op(input logic p, input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic exp_err, input logic [31:0] exp_rdata);
    op_t  o;
    exp_t e;
    o.we = we; o.f3 = f3; o.addr = addr; o.wdata = wdata;
    e.port = p; e.err = exp_err; e.rdata = exp_rdata;
    if (p) op1_q.push_back(o);
    else   op0_q.push_back(o);
    exp_q.push_back(e);
  endtask

  task automatic present(input int p, input op_t o);
    bus.req_valid[p]  = 1'b1;
    bus.req_we[p]     = o.we;
    bus.req_funct3[p] = o.f3;
    bus.req_addr[p]   = o.addr;
    bus.req_wdata[p]  = o.wdata;
  endtask

  task automatic run_ops(input int budget);
    int         n;
    logic [1:0] hs;
    n  = 0;
    hs = 2'b00;
    while ((op0_q.size() != 0 || op1_q.size() != 0 || bus.req_valid != 2'b00 ||
            exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
      for (int p = 0; p < 2; p++) if (hs[p]) bus.req_valid[p] = 1'b0;
      hs = 2'b00;
      if (!bus.req_valid[0] && op0_q.size() != 0) present(0, op0_q.pop_front());
      if (!bus.req_valid[1] && op1_q.size() != 0) present(1, op1_q.pop_front());
      #1;
      for (int p = 0; p < 2; p++) begin
        if (bus.req_valid[p] && bus.req_ready[p]) begin
          hs[p] = 1'b1;
          hs_q.push_back(cyc);
        end
      end
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    bus.req_valid = 2'b00;
    op0_q.delete();
    op1_q.delete();
    exp_q.delete();
    hs_q.delete();
  endtask

  int ctrl_before;

  initial begin
    bus.req_valid  = 2'b11;
    bus.req_we     = 2'b00;
    bus.req_funct3 = '0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    #12;
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp", {29'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
    chk("rst_rdata", bus.rsp_rdata, 32'd0);
    chk("rst_ctrl_f3", {22'd0, mem_ctrl, mem_funct3}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wr_data, 32'd0);
    bus.req_valid = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // port 0 store then load
    queue_op(1'b0, 1'b1, 3'b010, 32'd0, 32'h0000_0020, 1'b0, 32'h0);
    queue_op(1'b0, 1'b0, 3'b010, 32'd0, 32'h0,         1'b0, 32'h0000_0020);
    run_ops(60);

    // port 1 byte store, signed and unsigned byte loads
    queue_op(1'b1, 1'b1, 3'b000, 32'd5, 32'h0000_00F0, 1'b0, 32'h0);
    queue_op(1'b1, 1'b0, 3'b000, 32'd5, 32'h0,         1'b0, 32'hFFFF_FFF0);
    queue_op(1'b1, 1'b0, 3'b100, 32'd5, 32'h0,         1'b0, 32'h0000_00F0);
    run_ops(60);

    // both ports contend: responses expected in grant order 0,1,0,1,0,1
    queue_op(1'b0, 1'b1, 3'b010, 32'd16, 32'h1111_1111, 1'b0, 32'h0);
    queue_op(1'b1, 1'b0, 3'b010, 32'd16, 32'h0,         1'b0, 32'h1111_1111);
    queue_op(1'b0, 1'b1, 3'b010, 32'd20, 32'h2222_2222, 1'b0, 32'h0);
    queue_op(1'b1, 1'b0, 3'b101, 32'd20, 32'h0,         1'b0, 32'h0000_2222);
    queue_op(1'b0, 1'b0, 3'b010, 32'd16, 32'h0,         1'b0, 32'h1111_1111);
    queue_op(1'b1, 1'b0, 3'b000, 32'd23, 32'h0,         1'b0, 32'h0000_0022);
    run_ops(120);

    // misaligned load must never reach Memory
    ctrl_before = ctrl_cnt;
    queue_op(1'b0, 1'b0, 3'b010, 32'd2, 32'h0, 1'b1, 32'h0);
    run_ops(40);
    chk("misalign_no_mem", 32'(ctrl_cnt - ctrl_before), 32'd0);

    // range boundaries
    queue_op(1'b0, 1'b1, 3'b001, 32'd63, 32'h0000_ABCD, 1'b1, 32'h0);
    queue_op(1'b0, 1'b0, 3'b010, 32'd60, 32'h0,         1'b0, 32'h0);
    queue_op(1'b0, 1'b0, 3'b100, 32'd64, 32'h0,         1'b1, 32'h0);
    run_ops(60);

    // illegal store width leaves Memory untouched
    ctrl_before = ctrl_cnt;
    queue_op(1'b0, 1'b1, 3'b011, 32'd0, 32'hFFFF_FFFF, 1'b1, 32'h0);
    run_ops(40);
    chk("illegal_no_mem", 32'(ctrl_cnt - ctrl_before), 32'd0);
    queue_op(1'b0, 1'b0, 3'b010, 32'd0, 32'h0, 1'b0, 32'h0000_0020);
    run_ops(40);

    // reset during ISSUE of a store aborts it
    @(negedge clk);
    bus.req_valid[0]  = 1'b1;
    bus.req_we[0]     = 1'b1;
    bus.req_funct3[0] = 3'b010;
    bus.req_addr[0]   = 32'd8;
    bus.req_wdata[0]  = 32'hDEAD_BEEF;
    #1;
    chk("abort_ready", 32'(bus.req_ready), 32'h1);
    @(posedge clk);
    #1;
    chk("abort_issue", 32'(mem_ctrl), 32'h23);
    bus.req_valid = 2'b00;
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_ctrl_f3", {22'd0, mem_ctrl, mem_funct3}, 32'd0);
    chk("abort_addr_wd", mem_addr | mem_wr_data, 32'd0);
    chk("abort_rsp", {29'd0, bus.rsp_valid, bus.rsp_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    queue_op(1'b0, 1'b0, 3'b010, 32'd8, 32'h0, 1'b0, 32'h0);
    queue_op(1'b1, 1'b0, 3'b010, 32'd0, 32'h0, 1'b0, 32'h0000_0020);
    run_ops(60);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
